scan_doubler: RTL

Parametrised line-doubling buffer between the VIC-II core and the VGA/HDMI output path. Captures each incoming raster line of indexed pixels into one half of a ping-pong line RAM while replaying the previous line twice at double dot rate. Generates its own hsync/vsync/active timing from runtime line length and parameterised windows. Generalises the fixed single-chip VGA sync path to arbitrary colour width, line depth and per-line length, with an optional scanline-dimming flag.

---
 rtl/scan_doubler_if.sv | 27 ++
 rtl/scan_doubler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/scan_doubler_if.sv
// Video bus between the raster source and the line doubler: indexed dots in, timed dots out.
interface scan_doubler_if #(
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 9
);
  logic               pix_en;
  logic [X_W-1:0]     raster_x;
  logic [Y_W-1:0]     raster_y;
  logic [COLOR_W-1:0] pixel_in;
  logic [X_W-1:0]     line_len;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic [COLOR_W-1:0] pixel_out;
  logic               dim;

  modport master (
    output pix_en, raster_x, raster_y, pixel_in, line_len,
    input  hsync, vsync, active, pixel_out, dim
  );

  modport slave (
    input  pix_en, raster_x, raster_y, pixel_in, line_len,
    output hsync, vsync, active, pixel_out, dim
  );
endinterface

// File: rtl/scan_doubler.sv
// Ping-pong line doubler: captures one input raster line while replaying the previous one twice
// at double dot rate with generated syncs. Optional feature macro: SCANLINES_EN (drives dim).
module scan_doubler #(
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 9,
  parameter int unsigned DEPTH   = 520,
  parameter int unsigned HS_STA  = 10,
  parameter int unsigned HS_END  = 70,
  parameter int unsigned HA_STA  = 80,
  parameter int unsigned HA_END  = 500,
  parameter int unsigned VS_STA  = 4,
  parameter int unsigned VS_END  = 8,
  parameter int unsigned VA_STA  = 40,
  parameter int unsigned VA_END  = 560
) (
  input logic           clk_dot4x,
  input logic           rst,
  scan_doubler_if.slave vid_io
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned VW = Y_W + 1;

  localparam logic [X_W-1:0] DepthX = X_W'(DEPTH);
  localparam logic [X_W-1:0] XOne   = X_W'(1);
  localparam logic [X_W-1:0] HsSta  = X_W'(HS_STA);
  localparam logic [X_W-1:0] HsEnd  = X_W'(HS_END);
  localparam logic [X_W-1:0] HaSta  = X_W'(HA_STA);
  localparam logic [X_W-1:0] HaEnd  = X_W'(HA_END);
  localparam logic [VW-1:0]  VsSta  = VW'(VS_STA);
  localparam logic [VW-1:0]  VsEnd  = VW'(VS_END);
  localparam logic [VW-1:0]  VaSta  = VW'(VA_STA);
  localparam logic [VW-1:0]  VaEnd  = VW'(VA_END);

  localparam logic [1:0] StLine0 = 2'd0;
  localparam logic [1:0] StLine1 = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [COLOR_W-1:0] mem_q [2][DEPTH];
  logic [COLOR_W-1:0] rdata_q;

  logic [X_W-1:0] h_out_q, h_out_d, len_q, len_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           half_q, half_d, tick_q, tick_d, rbank_q, rbank_d;
  logic [1:0]     state_q, state_d;
  logic           line_start;
  logic [VW-1:0]  v_out;
  logic           hs_n, vs_n, act_n, rd_ok_n;
  logic           hs1_q, vs1_q, act1_q, rd_ok_q;
  logic           hsync_q, vsync_q, active_q;
  logic [COLOR_W-1:0] pixel_q;

  assign line_start = vid_io.pix_en && (vid_io.raster_x == '0);
  assign v_out      = {y_q, half_q};

  // Write bank follows raster_y parity; the read bank is always the other one.
  always_ff @(posedge clk_dot4x) begin
    if (vid_io.pix_en && (vid_io.raster_x < DepthX)) begin
      mem_q[vid_io.raster_y[0]][AW'(vid_io.raster_x)] <= vid_io.pixel_in;
    end
    rdata_q <= mem_q[rbank_q][AW'(h_out_q)];
  end

  always_comb begin
    h_out_d = h_out_q;
    half_d  = half_q;
    tick_d  = ~tick_q;
    state_d = state_q;
    len_d   = len_q;
    y_d     = y_q;
    rbank_d = rbank_q;
    if (line_start) begin
      len_d   = vid_io.line_len;
      y_d     = vid_io.raster_y;
      rbank_d = ~vid_io.raster_y[0];
      h_out_d = '0;
      half_d  = 1'b0;
      tick_d  = 1'b0;
      state_d = StLine0;
    end else if (tick_q && (state_q != StHold)) begin
      if (h_out_q == len_q - XOne) begin
        if (state_q == StLine0) begin
          h_out_d = '0;
          half_d  = 1'b1;
          state_d = StLine1;
        end else begin
          state_d = StHold;
        end
      end else begin
        h_out_d = h_out_q + XOne;
      end
    end
  end

  always_comb begin
    hs_n    = !((h_out_q >= HsSta) && (h_out_q < HsEnd));
    vs_n    = !((v_out >= VsSta) && (v_out < VsEnd));
    act_n   = (h_out_q >= HaSta) && (h_out_q < HaEnd) && (v_out >= VaSta) && (v_out < VaEnd)
              && (state_q != StHold);
    rd_ok_n = (h_out_q < DepthX);
  end

  // Stage 1 aligns timing flags with the RAM read, stage 2 registers the outputs.
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      h_out_q  <= '0;
      half_q   <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= StHold;
      len_q    <= DepthX;
      y_q      <= '0;
      rbank_q  <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      act1_q   <= 1'b0;
      rd_ok_q  <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      pixel_q  <= '0;
    end else begin
      h_out_q  <= h_out_d;
      half_q   <= half_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      len_q    <= len_d;
      y_q      <= y_d;
      rbank_q  <= rbank_d;
      hs1_q    <= hs_n;
      vs1_q    <= vs_n;
      act1_q   <= act_n;
      rd_ok_q  <= rd_ok_n;
      hsync_q  <= hs1_q;
      vsync_q  <= vs1_q;
      active_q <= act1_q;
      pixel_q  <= (act1_q && rd_ok_q) ? rdata_q : '0;
    end
  end

  assign vid_io.hsync     = hsync_q;
  assign vid_io.vsync     = vsync_q;
  assign vid_io.active    = active_q;
  assign vid_io.pixel_out = pixel_q;

`ifdef SCANLINES_EN
  logic half1_q, dim_q;

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      half1_q <= 1'b0;
      dim_q   <= 1'b0;
    end else begin
      half1_q <= half_q;
      dim_q   <= half1_q && act1_q;
    end
  end

  assign vid_io.dim = dim_q;
`else
  assign vid_io.dim = 1'b0;
`endif

endmodule
